// File: rtl/cpu_store_unit_pkg.sv
// Shared CPU definitions: store size encodings, store FSM states and the
// size-to-byte-mask helper used by the store alignment logic.
package cpu_store_unit_pkg;

    localparam logic [2:0] SIZE_B = 3'b000;
    localparam logic [2:0] SIZE_H = 3'b001;
    localparam logic [2:0] SIZE_W = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_e;

    // A zero mask marks an illegal size encoding.
    function automatic logic [3:0] size_mask(input logic [2:0] size);
        logic [3:0] mask;
        case (size)
            SIZE_B:  mask = 4'b0001;
            SIZE_H:  mask = 4'b0011;
            SIZE_W:  mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/cpu_store_align.sv
// Combinational store alignment: shifts byte mask and data into lane position
// across an 8-byte window and flags requests the unit cannot perform.
module cpu_store_align
    import cpu_store_unit_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic [1:0]  off,
    input  logic [2:0]  control,
    input  logic [31:0] data,
    output logic [7:0]  strb8,
    output logic [63:0] data64,
    output logic        legal
);

    logic [3:0] mask_s;

    // Lane placement and legality check for the incoming request.
    always_comb begin
        mask_s = size_mask(control);
        strb8  = {4'b0000, mask_s} << off;
        data64 = {32'h0000_0000, data} << {off, 3'b000};
        if (mask_s == 4'b0000) begin
            legal = 1'b0;
        end else if (!ALLOW_MISALIGNED && (strb8[7:4] != 4'b0000)) begin
            legal = 1'b0;
        end else begin
            legal = 1'b1;
        end
    end

endmodule

// File: rtl/cpu_store_unit.sv
// Store unit: accepts one store at a time and issues one or two word-aligned
// write beats, then pulses done (or err for rejected requests).
module cpu_store_unit
    import cpu_store_unit_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [2:0]  req_control,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        done,
    output logic        err
);

    state_e      state_r;
    logic [31:0] addr_r;
    logic [3:0]  strb_hi_r;
    logic [31:0] data_hi_r;
    logic        req_ready_r;
    logic        mem_valid_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [3:0]  mem_wstrb_r;
    logic        done_r;
    logic        err_r;

    logic [7:0]  strb8_s;
    logic [63:0] data64_s;
    logic        legal_s;
    logic        hs_s;

    cpu_store_align #(
        .ALLOW_MISALIGNED(ALLOW_MISALIGNED)
    ) u_align (
        .off     (req_addr[1:0]),
        .control (req_control),
        .data    (req_data),
        .strb8   (strb8_s),
        .data64  (data64_s),
        .legal   (legal_s)
    );

    assign hs_s = req_valid & req_ready_r;

    // Store sequencing FSM; every bus/handshake output is a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            addr_r      <= 32'h0000_0000;
            strb_hi_r   <= 4'b0000;
            data_hi_r   <= 32'h0000_0000;
            req_ready_r <= 1'b1;
            mem_valid_r <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            mem_wstrb_r <= 4'b0000;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (hs_s) begin
                        addr_r      <= {req_addr[31:2], 2'b00};
                        strb_hi_r   <= strb8_s[7:4];
                        data_hi_r   <= data64_s[63:32];
                        req_ready_r <= 1'b0;
                        if (legal_s) begin
                            state_r     <= BEAT0;
                            mem_valid_r <= 1'b1;
                            mem_addr_r  <= {req_addr[31:2], 2'b00};
                            mem_wstrb_r <= strb8_s[3:0];
                            mem_wdata_r <= data64_s[31:0];
                        end else begin
                            state_r <= RESP;
                            err_r   <= 1'b1;
                        end
                    end
                end
                BEAT0: begin
                    if (mem_ready) begin
                        if (strb_hi_r != 4'b0000) begin
                            state_r     <= BEAT1;
                            mem_addr_r  <= addr_r + 32'd4;
                            mem_wstrb_r <= strb_hi_r;
                            mem_wdata_r <= data_hi_r;
                        end else begin
                            state_r     <= RESP;
                            mem_valid_r <= 1'b0;
                            done_r      <= 1'b1;
                        end
                    end
                end
                BEAT1: begin
                    if (mem_ready) begin
                        state_r     <= RESP;
                        mem_valid_r <= 1'b0;
                        done_r      <= 1'b1;
                    end
                end
                RESP: begin
                    state_r     <= IDLE;
                    done_r      <= 1'b0;
                    err_r       <= 1'b0;
                    req_ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= IDLE;
                    mem_valid_r <= 1'b0;
                    done_r      <= 1'b0;
                    err_r       <= 1'b0;
                    req_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign mem_valid = mem_valid_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_wstrb = mem_wstrb_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_cpu_store_unit.sv
// Self-checking bench for cpu_store_unit: scoreboard of expected write beats
// consumed by a bus monitor, plus per-scenario latency and pulse checks.
module tb_cpu_store_unit;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_valid_b;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [2:0]  req_control;
    logic        mem_ready;

    logic        req_ready, mem_valid, done, err;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    logic        req_ready_b, mem_valid_b, done_b, err_b;
    logic [31:0] mem_addr_b, mem_wdata_b;
    logic [3:0]  mem_wstrb_b;

    beat_t exp_q[$];
    beat_t mon_e;
    int    checks = 0;
    int    failures = 0;

    cpu_store_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_control(req_control),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .done(done), .err(err)
    );

    cpu_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_addr(req_addr), .req_data(req_data), .req_control(req_control),
        .mem_valid(mem_valid_b), .mem_ready(mem_ready), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_wstrb(mem_wstrb_b), .done(done_b), .err(err_b)
    );

    always #5 clk = ~clk;

    // Bus monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if ((done === 1'b1) && (err === 1'b1)) begin
                failures++;
                $display("FAIL done_err_overlap got done=%b err=%b required not both", done, err);
            end
            if ((mem_valid === 1'b1) && (mem_ready === 1'b1)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat got addr=%h wdata=%h strb=%b required none",
                             mem_addr, mem_wdata, mem_wstrb);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({mem_addr, mem_wdata, mem_wstrb} !== mon_e) begin
                        failures++;
                        $display("FAIL beat got addr=%h wdata=%h strb=%b required addr=%h wdata=%h strb=%b",
                                 mem_addr, mem_wdata, mem_wstrb, mon_e.addr, mon_e.wdata, mon_e.strb);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        beat_t b;
        b.addr = a; b.wdata = d; b.strb = s;
        exp_q.push_back(b);
    endtask

    // One store through the main DUT; optionally also through dut_b (expected to reject).
    task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c,
                             input int stall0, input int exp_cyc, input logic exp_err,
                             input logic to_b, input string name);
        int    cyc;
        logic  seen;
        logic  pv, pr;
        logic [67:0] pbus;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready_idle got %b required 1", name, req_ready);
        end
        req_valid = 1'b1; req_valid_b = to_b;
        req_addr = a; req_data = d; req_control = c;
        @(posedge clk); #1;
        // Keep req_valid high with different payload: must be ignored while busy.
        req_valid_b = 1'b0;
        req_addr = ~a; req_data = ~d; req_control = 3'b000;
        seen = 1'b0; cyc = 0; pv = 1'b0; pr = 1'b1; pbus = '0;
        for (int i = 1; i <= 30 && !seen; i++) begin
            if (i > 1) begin @(posedge clk); #1; end
            mem_ready = (i > stall0);
            @(negedge clk);
            if (pv && !pr) begin
                checks++;
                if ({mem_addr, mem_wdata, mem_wstrb} !== pbus) begin
                    failures++;
                    $display("FAIL %s_stall_hold got %h required %h", name,
                             {mem_addr, mem_wdata, mem_wstrb}, pbus);
                end
            end
            pv = mem_valid; pr = mem_ready; pbus = {mem_addr, mem_wdata, mem_wstrb};
            if (to_b) begin
                checks++;
                if ({mem_valid_b, err_b, done_b} !== {1'b0, (i == 1), 1'b0}) begin
                    failures++;
                    $display("FAIL %s_b_cycle%0d got valid=%b err=%b done=%b required valid=0 err=%b done=0",
                             name, i, mem_valid_b, err_b, done_b, (i == 1));
                end
            end
            if ((done === 1'b1) || (err === 1'b1)) begin
                seen = 1'b1; cyc = i;
            end else begin
                checks++;
                if (req_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_ready_busy got %b required 0", name, req_ready);
                end
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout got no done/err required pulse", name);
        end else begin
            checks++;
            if (cyc != exp_cyc) begin
                failures++;
                $display("FAIL %s_latency got %0d required %0d", name, cyc, exp_cyc);
            end
            checks++;
            if ({done, err, mem_valid, req_ready} !== {~exp_err, exp_err, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL %s_resp got done=%b err=%b valid=%b ready=%b required done=%b err=%b valid=0 ready=0",
                         name, done, err, mem_valid, req_ready, ~exp_err, exp_err);
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({done, err, mem_valid, req_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL %s_after got done=%b err=%b valid=%b ready=%b required 0 0 0 1",
                     name, done, err, mem_valid, req_ready);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_beats_left got %0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_valid_b = 1'b0; mem_ready = 1'b1;
        req_addr = 32'h0; req_data = 32'h0; req_control = 3'b000;
        #13;
        checks++;
        if ({req_ready, mem_valid, done, err, mem_addr, mem_wdata, mem_wstrb} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0}) begin
            failures++;
            $display("FAIL reset_state got ready=%b valid=%b done=%b err=%b addr=%h wdata=%h strb=%b required 1 0 0 0 0 0 0",
                     req_ready, mem_valid, done, err, mem_addr, mem_wdata, mem_wstrb);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_byte();
        push(32'h0000_1000, 32'hAB00_0000, 4'b1000);
        run_store(32'h0000_1003, 32'h0000_00AB, 3'b000, 0, 2, 1'b0, 1'b0, "byte");
    endtask

    task automatic test_split_word();
        push(32'h0000_2000, 32'h3344_0000, 4'b1100);
        push(32'h0000_2004, 32'h0000_1122, 4'b0011);
        run_store(32'h0000_2002, 32'h1122_3344, 3'b010, 0, 3, 1'b0, 1'b0, "split_word");
    endtask

    task automatic test_wrap();
        push(32'hFFFF_FFFC, 32'hEF00_0000, 4'b1000);
        push(32'h0000_0000, 32'h0000_00BE, 4'b0001);
        run_store(32'hFFFF_FFFF, 32'h0000_BEEF, 3'b001, 0, 3, 1'b0, 1'b0, "wrap_half");
    endtask

    task automatic test_stall();
        push(32'h0000_3000, 32'hCAFE_F00D, 4'b1111);
        run_store(32'h0000_3000, 32'hCAFE_F00D, 3'b010, 3, 5, 1'b0, 1'b0, "stall_word");
    endtask

    task automatic test_illegal();
        run_store(32'h0000_4000, 32'h1234_5678, 3'b011, 0, 1, 1'b1, 1'b0, "illegal_011");
        run_store(32'h0000_4000, 32'h1234_5678, 3'b111, 0, 1, 1'b1, 1'b0, "illegal_111");
    endtask

    task automatic test_misaligned_reject();
        push(32'h0000_1000, 32'h6677_8800, 4'b1110);
        push(32'h0000_1004, 32'h0000_0055, 4'b0001);
        run_store(32'h0000_1001, 32'h5566_7788, 3'b010, 0, 3, 1'b0, 1'b1, "misaligned");
    endtask

    task automatic test_reset_mid_beat1();
        push(32'h0000_2000, 32'h3344_0000, 4'b1100);
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_2002; req_data = 32'h1122_3344; req_control = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({mem_valid, mem_addr} !== {1'b1, 32'h0000_2004}) begin
            failures++;
            $display("FAIL rst_mid_in_beat1 got valid=%b addr=%h required 1 00002004", mem_valid, mem_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_valid, done, err, mem_addr, req_ready} !== {1'b0, 1'b0, 1'b0, 32'h0, 1'b1}) begin
            failures++;
            $display("FAIL rst_mid_async got valid=%b done=%b err=%b addr=%h ready=%b required 0 0 0 0 1",
                     mem_valid, done, err, mem_addr, req_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ((done !== 1'b0) || (mem_valid !== 1'b0)) begin
                failures++;
                $display("FAIL rst_mid_no_done got done=%b valid=%b required 0 0", done, mem_valid);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rst_mid_beats_left got %0d required 0", exp_q.size());
            exp_q.delete();
        end
        push(32'h0000_5004, 32'h0000_7700, 4'b0010);
        run_store(32'h0000_5005, 32'h0000_0077, 3'b000, 0, 2, 1'b0, 1'b0, "post_reset");
    endtask

    task automatic test_random();
        logic [31:0] a, d, base;
        logic [2:0]  c;
        logic [3:0]  m;
        logic [7:0]  s8;
        logic [63:0] d64;
        int          st, ec;
        for (int n = 0; n < 12; n++) begin
            a = $urandom; d = $urandom; c = 3'($urandom_range(0, 3)); st = $urandom_range(0, 2);
            case (c)
                3'b000:  m = 4'b0001;
                3'b001:  m = 4'b0011;
                3'b010:  m = 4'b1111;
                default: m = 4'b0000;
            endcase
            s8   = {4'b0000, m} << a[1:0];
            d64  = {32'h0, d} << (8 * a[1:0]);
            base = {a[31:2], 2'b00};
            if (m == 4'b0000) begin
                ec = 1;
            end else begin
                push(base, d64[31:0], s8[3:0]);
                if (s8[7:4] != 4'b0000) begin
                    push(base + 32'd4, d64[63:32], s8[7:4]);
                    ec = 3 + st;
                end else begin
                    ec = 2 + st;
                end
            end
            run_store(a, d, c, (m == 4'b0000) ? 0 : st, ec, (m == 4'b0000), 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_byte();
        test_split_word();
        test_wrap();
        test_stall();
        test_illegal();
        test_misaligned_reject();
        test_reset_mid_beat1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_store_unit.md
CPU_STORE_UNIT -- requirements
Module: cpu_store_unit

Interface
REQ-001 SHALL have parameter: ALLOW_MISALIGNED, default 1, 1 = misaligned stores split into two beats, 0 = misaligned stores rejected with err.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  input  1  store request present.
REQ-005 SHALL have port: req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port: req_addr  input  32  byte address of the store.
REQ-007 SHALL have port: req_data  input  32  store data, right-aligned.
REQ-008 SHALL have port: req_control  input  3  size: 000 byte, 001 half, 010 word, others illegal.
REQ-009 SHALL have port: mem_valid  output  1  write beat present on bus.
REQ-010 SHALL have port: mem_ready  input  1  memory accepts beat.
REQ-011 SHALL have port: mem_addr  output  32  word-aligned address; bits [1:0] always 00.
REQ-012 SHALL have port: mem_wdata  output  32  lane-aligned write data.
REQ-013 SHALL have port: mem_wstrb  output  4  byte-lane write enables.
REQ-014 SHALL have port: done  output  1  one-cycle pulse: store completed.
REQ-015 SHALL have port: err  output  1  one-cycle pulse: request rejected.

Function
REQ-016 SHALL use FSM states IDLE, BEAT0, BEAT1, RESP.
REQ-017 SHALL drive req_ready = 1 only in IDLE; handshake = req_valid & req_ready; addr/data/control latched on handshake.
REQ-018 SHALL compute off = addr[1:0], mask = 0001/0011/1111 per size, strb8 = mask << off, data64 = data << 8*off (zero-filled).
REQ-019 SHALL, on a legal handshake, enter BEAT0 next cycle with mem_valid=1, mem_addr={addr[31:2],00}, mem_wstrb=strb8[3:0], mem_wdata=data64[31:0].
REQ-020 SHALL hold mem_addr/mem_wdata/mem_wstrb stable while mem_valid & ~mem_ready.
REQ-021 SHALL, on BEAT0 accept, go to BEAT1 if strb8[7:4] != 0, else RESP.
REQ-022 SHALL in BEAT1 drive mem_addr = {addr[31:2],00}+4 (mod 2^32, 0xFFFFFFFC wraps to 0x00000000), mem_wstrb=strb8[7:4], mem_wdata=data64[63:32]; on accept go to RESP.
REQ-023 SHALL in RESP assert done for exactly one cycle, mem_valid=0, then return to IDLE; req_ready=0 in RESP.
REQ-024 SHALL treat illegal control, or strb8[7:4]!=0 with ALLOW_MISALIGNED=0, as rejected: no bus beat, go to RESP with err=1 and done=0.
REQ-025 SHALL never assert done and err in the same cycle; mem_valid low in IDLE and RESP.
REQ-026 SHALL have latency: aligned store done 2 cycles after req handshake with mem_ready held 1; split store 3 cycles; each mem_ready stall adds one cycle.
REQ-027 SHALL ignore req_valid outside IDLE (no queueing).

Reset
REQ-028 SHALL on rst_n=0 asynchronously force IDLE, mem_valid=0, done=0, err=0, mem_addr/mem_wdata/mem_wstrb=0; req_ready=1 while in IDLE.
REQ-029 SHALL, on reset mid-beat, abandon the store with no completion pulse; a half-written split store is not rolled back.

Structure
REQ-030 SHALL take size encodings (SIZE_B/H/W) and FSM state encoding from the shared cpu package, common with cpu_data_extend.
REQ-031 SHALL contain one combinational sub-module cpu_store_align (addr offset, control, data -> strb8, data64, legal).

Verification
REQ-032 SHALL cover: byte store addr 0x1003 data 0x000000AB, mem_ready=1 -> one beat addr 0x1000 wstrb 1000 wdata 0xAB000000, done 2 cycles later.
REQ-033 SHALL cover: word store addr 0x2002 data 0x11223344 -> beat0 0x2000 strb 1100 wdata 0x33440000; beat1 0x2004 strb 0011 wdata 0x00001122; done.
REQ-034 SHALL cover: half store addr 0xFFFFFFFF data 0xBEEF -> beat0 0xFFFFFFFC strb 1000 wdata 0xEF000000; beat1 0x00000000 strb 0001 wdata 0x000000BE.
REQ-035 SHALL cover: mem_ready low 3 cycles during beat0 -> bus outputs unchanged, done delayed 3 cycles.
REQ-036 SHALL cover: control 011, and ALLOW_MISALIGNED=0 with word at 0x1001 -> no mem_valid, err pulse one cycle, done stays 0.
REQ-037 SHALL cover: rst_n low during BEAT1 -> mem_valid 0 immediately, no done; next request accepted normally.
